hack_ps2_keyboard_writer: RTL and testbench

- Producer side of the Hack keyboard register: receives PS/2 (scan code set 2) frames from the keyboard pins and decodes make/break sequences into Hack key codes.
- Drives a load strobe and a 16-bit code into the keyboard register.
- The register then holds the code of the currently pressed key, or 0 when no key is pressed.

---
 rtl/hack_ps2_keyboard_writer.sv | 226 ++++++++++++++++++++++
 tb/tb_hack_ps2_keyboard_writer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hack_ps2_keyboard_writer.sv
// PS/2 keyboard front end for the Hack keyboard register.
// Receives scan-code-set-2 frames, tracks make/break/extended prefixes and
// shift state, and emits a one-cycle load strobe with the Hack key code
// (or 0 when the held key is released).
module hack_ps2_keyboard_writer #(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic        kbd_load,
    output logic [15:0] kbd_code,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    logic [1:0]    clk_sync, dat_sync;
    logic          clk_prev, fall;
    logic [3:0]    bit_cnt;
    logic [9:0]    shreg;
    logic [10:0]   full;
    logic [TW-1:0] to_cnt;
    logic          byte_valid;
    logic [7:0]    byte_q;

    state_t        state, state_nx;
    logic          lshift, rshift, held_vld;
    logic [8:0]    held_key;
    logic          lshift_nx, rshift_nx, held_vld_nx, load_nx;
    logic [8:0]    held_key_nx;
    logic [15:0]   code_nx;
    logic          ev_make, ev_brk, ev_ext;
    logic [7:0]    mapped;

    // Scan code to Hack code; 0 means unmapped.
    function automatic logic [7:0] map_key(input logic ext, input logic shift, input logic [7:0] b);
        map_key = 8'd0;
        if (ext) begin
            case (b)
                8'h6B: map_key = 8'd130;
                8'h75: map_key = 8'd131;
                8'h74: map_key = 8'd132;
                8'h72: map_key = 8'd133;
                8'h6C: map_key = 8'd134;
                8'h69: map_key = 8'd135;
                8'h7D: map_key = 8'd136;
                8'h7A: map_key = 8'd137;
                8'h70: map_key = 8'd138;
                8'h71: map_key = 8'd139;
                default: map_key = 8'd0;
            endcase
        end else begin
            case (b)
                8'h1C: map_key = 8'd65;  8'h32: map_key = 8'd66;
                8'h21: map_key = 8'd67;  8'h23: map_key = 8'd68;
                8'h24: map_key = 8'd69;  8'h2B: map_key = 8'd70;
                8'h34: map_key = 8'd71;  8'h33: map_key = 8'd72;
                8'h43: map_key = 8'd73;  8'h3B: map_key = 8'd74;
                8'h42: map_key = 8'd75;  8'h4B: map_key = 8'd76;
                8'h3A: map_key = 8'd77;  8'h31: map_key = 8'd78;
                8'h44: map_key = 8'd79;  8'h4D: map_key = 8'd80;
                8'h15: map_key = 8'd81;  8'h2D: map_key = 8'd82;
                8'h1B: map_key = 8'd83;  8'h2C: map_key = 8'd84;
                8'h3C: map_key = 8'd85;  8'h2A: map_key = 8'd86;
                8'h1D: map_key = 8'd87;  8'h22: map_key = 8'd88;
                8'h35: map_key = 8'd89;  8'h1A: map_key = 8'd90;
                8'h45: map_key = shift ? 8'd41 : 8'd48;
                8'h16: map_key = shift ? 8'd33 : 8'd49;
                8'h1E: map_key = shift ? 8'd64 : 8'd50;
                8'h26: map_key = shift ? 8'd35 : 8'd51;
                8'h25: map_key = shift ? 8'd36 : 8'd52;
                8'h2E: map_key = shift ? 8'd37 : 8'd53;
                8'h36: map_key = shift ? 8'd94 : 8'd54;
                8'h3D: map_key = shift ? 8'd38 : 8'd55;
                8'h3E: map_key = shift ? 8'd42 : 8'd56;
                8'h46: map_key = shift ? 8'd40 : 8'd57;
                8'h29: map_key = 8'd32;
                8'h5A: map_key = 8'd128;
                8'h66: map_key = 8'd129;
                8'h76: map_key = 8'd140;
                default: map_key = 8'd0;
            endcase
        end
    endfunction

    // Two-flop synchronisers; reset to idle-high so no false edge follows reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_prev <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_prev <= clk_sync[1];
        end
    end

    assign fall = clk_prev & ~clk_sync[1];
    // bit 0 start, 8:1 data, 9 parity, 10 stop (current bit is the stop bit)
    assign full = {dat_sync[1], shreg};

    // Frame receiver with inactivity timeout; checks the frame on the 11th edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            to_cnt     <= '0;
            byte_valid <= 1'b0;
            byte_q     <= '0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= '0;
                    if (!full[0] && (^full[9:1]) && full[10]) begin
                        byte_valid <= 1'b1;
                        byte_q     <= full[8:1];
                    end else begin
                        frame_err  <= 1'b1;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shreg   <= {dat_sync[1], shreg[9:1]};
                end
            end else if (bit_cnt != 4'd0) begin
                if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

    // Decoder state, shift flags, held key and register-facing outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            lshift   <= 1'b0;
            rshift   <= 1'b0;
            held_vld <= 1'b0;
            held_key <= '0;
            kbd_load <= 1'b0;
            kbd_code <= '0;
        end else begin
            state    <= state_nx;
            lshift   <= lshift_nx;
            rshift   <= rshift_nx;
            held_vld <= held_vld_nx;
            held_key <= held_key_nx;
            kbd_load <= load_nx;
            kbd_code <= code_nx;
        end
    end

    // Prefix tracking and make/break resolution for each received byte.
    always_comb begin
        state_nx    = state;
        lshift_nx   = lshift;
        rshift_nx   = rshift;
        held_vld_nx = held_vld;
        held_key_nx = held_key;
        load_nx     = 1'b0;
        code_nx     = kbd_code;
        ev_make     = 1'b0;
        ev_brk      = 1'b0;
        ev_ext      = 1'b0;
        if (byte_valid) begin
            case (state)
                S_IDLE: begin
                    if (byte_q == 8'hE0)      state_nx = S_EXT;
                    else if (byte_q == 8'hF0) state_nx = S_BRK;
                    else if (byte_q == 8'hAA || byte_q == 8'hFA || byte_q == 8'hEE ||
                             byte_q == 8'hFE || byte_q == 8'h00 || byte_q == 8'hFF) begin
                        // keyboard status/ack bytes carry no key event
                    end
                    else if (byte_q == 8'h12) lshift_nx = 1'b1;
                    else if (byte_q == 8'h59) rshift_nx = 1'b1;
                    else                      ev_make = 1'b1;
                end
                S_EXT: begin
                    if (byte_q == 8'hF0)      state_nx = S_EXT_BRK;
                    else if (byte_q == 8'hE0) state_nx = S_EXT;
                    else begin
                        ev_make  = 1'b1;
                        ev_ext   = 1'b1;
                        state_nx = S_IDLE;
                    end
                end
                S_BRK: begin
                    state_nx = S_IDLE;
                    if (byte_q == 8'h12)      lshift_nx = 1'b0;
                    else if (byte_q == 8'h59) rshift_nx = 1'b0;
                    else                      ev_brk = 1'b1;
                end
                default: begin
                    state_nx = S_IDLE;
                    ev_brk   = 1'b1;
                    ev_ext   = 1'b1;
                end
            endcase
        end
        mapped = map_key(ev_ext, lshift | rshift, byte_q);
        if (ev_make && mapped != 8'd0) begin
            held_vld_nx = 1'b1;
            held_key_nx = {ev_ext, byte_q};
            code_nx     = {8'd0, mapped};
            load_nx     = 1'b1;
        end
        if (ev_brk && held_vld && held_key == {ev_ext, byte_q}) begin
            held_vld_nx = 1'b0;
            code_nx     = 16'd0;
            load_nx     = 1'b1;
        end
    end

endmodule

// File: tb/tb_hack_ps2_keyboard_writer.sv
// Bench for hack_ps2_keyboard_writer: directed scenarios then random key
// events, each frame checked cycle-by-cycle against a key-event model.
module tb_hack_ps2_keyboard_writer;

    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic        kbd_load;
    logic [15:0] kbd_code;
    logic        frame_err;

    hack_ps2_keyboard_writer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .kbd_load(kbd_load), .kbd_code(kbd_code), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    int load_total = 0, exp_loads = 0;

    // every strobe cycle, anywhere in the run
    always @(negedge clk) if (kbd_load === 1'b1) load_total++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int letters[26] = '{'h1C,'h32,'h21,'h23,'h24,'h2B,'h34,'h33,'h43,'h3B,'h42,'h4B,'h3A,
                        'h31,'h44,'h4D,'h15,'h2D,'h1B,'h2C,'h3C,'h2A,'h1D,'h22,'h35,'h1A};
    int digits[10]  = '{'h45,'h16,'h1E,'h26,'h25,'h2E,'h36,'h3D,'h3E,'h46};
    int dshift[10]  = '{41,33,64,35,36,37,94,38,42,40};
    int extk[10]    = '{'h6B,'h75,'h74,'h72,'h6C,'h69,'h7D,'h7A,'h70,'h71};
    int ignb[6]     = '{'hAA,'hFA,'hEE,'hFE,'h00,'hFF};

    bit m_lsh, m_rsh, m_hv;
    int m_hkey, m_code;
    int pend[$];

    function automatic int kmap(bit ext, bit sh, int b);
        if (ext) begin
            foreach (extk[i]) if (extk[i] == b) return 130 + i;
            return 0;
        end
        foreach (letters[i]) if (letters[i] == b) return 65 + i;
        foreach (digits[i])  if (digits[i] == b) return sh ? dshift[i] : 48 + i;
        case (b)
            'h29: return 32;
            'h5A: return 128;
            'h66: return 129;
            'h76: return 140;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_lsh = 0; m_rsh = 0; m_hv = 0; m_hkey = 0; m_code = 0;
        pend.delete();
    endtask

    // Collect prefix bytes; act once the key byte of a sequence arrives.
    task automatic model_byte(input int b, output bit st);
        bit ext, brk;
        int v;
        st = 0;
        pend.push_back(b);
        if (b == 'hE0 || b == 'hF0) return;
        ext = 0; brk = 0;
        foreach (pend[i]) begin
            if (pend[i] == 'hE0) ext = 1;
            if (pend[i] == 'hF0) brk = 1;
        end
        pend.delete();
        if (!ext && !brk) foreach (ignb[i]) if (ignb[i] == b) return;
        if (!ext && b == 'h12) begin m_lsh = !brk; return; end
        if (!ext && b == 'h59) begin m_rsh = !brk; return; end
        if (brk) begin
            if (m_hv && m_hkey == (int'(ext) * 256 + b)) begin
                m_hv = 0; m_code = 0; st = 1;
            end
        end else begin
            v = kmap(ext, m_lsh | m_rsh, b);
            if (v != 0) begin
                m_hv = 1; m_hkey = int'(ext) * 256 + b; m_code = v; st = 1;
            end
        end
    endtask

    // ---------------- PS/2 drivers ----------------
    function automatic logic [10:0] mkframe(input int b, input int kind);
        logic [7:0] d;
        d = b[7:0];
        mkframe = {kind == 2 ? 1'b0 : 1'b1, (~^d) ^ (kind == 1), d, kind == 3 ? 1'b1 : 1'b0};
    endfunction

    task automatic send_bit(input logic v);
        @(negedge clk) ps2_data = v;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_partial(input int b, input int nbits);
        logic [10:0] fr;
        fr = mkframe(b, 0);
        for (int i = 0; i < nbits; i++) send_bit(fr[i]);
    endtask

    // kind: 0 good, 1 bad parity, 2 bad stop, 3 bad start
    task automatic send_frame(input int b, input int kind);
        logic [10:0] fr;
        int nload, lpos, lcode, nerr, epos;
        bit st;
        fr = mkframe(b, kind);
        for (int i = 0; i < 10; i++) send_bit(fr[i]);
        @(negedge clk) ps2_data = fr[10];
        repeat (2) @(negedge clk);
        ps2_clk = 1'b0;
        nload = 0; lpos = 0; lcode = 0; nerr = 0; epos = 0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (kbd_load === 1'b1) begin nload++; lpos = c; lcode = kbd_code; end
            if (frame_err === 1'b1) begin nerr++; epos = c; end
        end
        ps2_clk = 1'b1;
        st = 0;
        if (kind == 0) model_byte(b, st);
        exp_loads += int'(st);
        chk($sformatf("load_cnt[%02h]", b), nload, int'(st));
        if (st && nload == 1) begin
            chk($sformatf("load_lat[%02h]", b), lpos, 4);
            chk($sformatf("code[%02h]", b), lcode, m_code);
        end
        chk($sformatf("err_cnt[%02h/k%0d]", b, kind), nerr, int'(kind != 0));
        if (kind != 0 && nerr == 1) chk("err_lat", epos, 3);
        chk($sformatf("code_hold[%02h]", b), kbd_code, m_code);
        repeat (3) @(negedge clk);
    endtask

    task automatic good(input int b);
        send_frame(b, 0);
    endtask

    task automatic key(input int b, input bit ext, input bit brk);
        if (ext) good('hE0);
        if (brk) good('hF0);
        good(b);
    endtask

    task automatic do_reset();
        @(negedge clk) reset = 1'b1;
        ps2_clk = 1'b1; ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        int r, k;
        bit brk;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_load", kbd_load, 0);
        chk("rst_code", kbd_code, 0);
        chk("rst_err", frame_err, 0);

        // partial frame cut by reset
        send_partial('h55, 5);
        do_reset();
        chk("rst2_code", kbd_code, 0);
        good('h1C);

        do_reset();
        key('h1C, 0, 0); key('h1C, 0, 1);
        key('h12, 0, 0); key('h16, 0, 0); key('h16, 0, 1); key('h12, 0, 1); key('h16, 0, 0);
        key('h75, 1, 0); key('h75, 1, 1);
        good('h5A); good('h66);
        send_frame('h1C, 1); send_frame('h1C, 2); send_frame('h1C, 3);
        good('h32);
        // timeout of a stalled partial frame
        send_partial('h1C, 4);
        repeat (TO + 6) @(negedge clk);
        good('h29);
        key('h29, 0, 1);
        key('h1C, 0, 0); key('h32, 0, 0); key('h1C, 0, 1); key('h32, 0, 1);
        good('h0E); good('hAA);
        key('h1C, 0, 0); key('h1C, 0, 0);   // typematic repeat

        // random key events
        for (int n = 0; n < 90; n++) begin
            r = $urandom_range(0, 11);
            brk = $urandom_range(0, 2) == 0;
            case (r)
                0, 1, 2: key(letters[$urandom_range(0, 25)], 0, brk);
                3, 4:    key(digits[$urandom_range(0, 9)], 0, brk);
                5:       begin k = $urandom_range(0, 3);
                               key(k == 0 ? 'h29 : k == 1 ? 'h5A : k == 2 ? 'h66 : 'h76, 0, brk); end
                6:       key(extk[$urandom_range(0, 9)], 1, brk);
                7:       key($urandom_range(0, 1) ? 'h12 : 'h59, 0, brk);
                8:       good(ignb[$urandom_range(0, 5)]);
                9:       key('h0E, 0, brk);
                10:      send_frame($urandom_range(0, 255), $urandom_range(1, 3));
                default: key(letters[$urandom_range(0, 25)], 0, 1);
            endcase
        end

        chk("total_loads", load_total, exp_loads);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
